// File: rtl/alu_multiword_sequencer.sv
// Sequences a shared 16-bit ALU through an N-word add/subtract, least-significant word first,
// chaining carry/borrow between words and writing each result word back to the operand store.
`ifndef ADDC
`define ADDC 4'h2
`endif
`ifndef SUBC
`define SUBC 4'h3
`endif

module alu_multiword_sequencer #(
  parameter int MAX_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [IDX_W:0]   num_words,
  input  logic             cin,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [15:0]      a_word,
  input  logic [15:0]      b_word,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [15:0]      alu_operand1,
  output logic [15:0]      alu_operand2,
  output logic             alu_carry_in,
  output logic [3:0]       alu_opcode,
  input  logic [15:0]      alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [15:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             carry_final,
  output logic             zero_all
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   len_q, len_d;
  logic             op_sub_q, op_sub_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             carry_final_q, carry_final_d;
  logic             zero_all_q, zero_all_d;
  logic             alu_req_q, alu_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W:0]   len_clamped;
  logic             last_word;
  logic             in_run;

  assign len_clamped = (num_words > MAX_LEN) ? MAX_LEN : num_words;
  assign last_word   = (idx_q == IDX_W'(len_q - 1'b1));
  assign in_run      = (state_q == RUN);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    op_sub_d      = op_sub_q;
    carry_d       = carry_q;
    zacc_d        = zacc_q;
    carry_final_d = carry_final_q;
    zero_all_d    = zero_all_q;
    alu_req_d     = alu_req_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len_clamped == '0) begin
            // Empty operation: the result is just the incoming carry.
            carry_final_d = cin;
            zero_all_d    = 1'b1;
            done_d        = 1'b1;
            alu_req_d     = 1'b0;
            state_d       = DONE;
          end else begin
            op_sub_d  = op_sub;
            len_d     = len_clamped;
            carry_d   = cin;
            zacc_d    = 1'b1;
            idx_d     = '0;
            alu_req_d = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (alu_gnt) begin
          carry_d = alu_carry_out;
          zacc_d  = zacc_q & alu_zero;
          if (last_word) begin
            // idx parks on the last word rather than wrapping.
            carry_final_d = alu_carry_out;
            zero_all_d    = zacc_q & alu_zero;
            alu_req_d     = 1'b0;
            done_d        = 1'b1;
            state_d       = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        alu_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      op_sub_q      <= 1'b0;
      carry_q       <= 1'b0;
      zacc_q        <= 1'b0;
      carry_final_q <= 1'b0;
      zero_all_q    <= 1'b0;
      alu_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      op_sub_q      <= op_sub_d;
      carry_q       <= carry_d;
      zacc_q        <= zacc_d;
      carry_final_q <= carry_final_d;
      zero_all_q    <= zero_all_d;
      alu_req_q     <= alu_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // The ALU and write port see the current word in the same cycle the store presents it.
  assign rd_idx       = idx_q;
  assign alu_req      = alu_req_q;
  assign alu_operand1 = in_run ? a_word : 16'h0000;
  assign alu_operand2 = in_run ? b_word : 16'h0000;
  assign alu_carry_in = carry_q;
  assign alu_opcode   = (in_run && op_sub_q) ? `SUBC : `ADDC;
  assign wr_en        = in_run & alu_gnt;
  assign wr_idx       = idx_q;
  assign wr_data      = wr_en ? alu_result : 16'h0000;
  assign busy         = busy_q;
  assign done         = done_q;
  assign carry_final  = carry_final_q;
  assign zero_all     = zero_all_q;

endmodule

// File: doc/alu_multiword_sequencer.md
Name: alu_multiword_sequencer

Overview:
- Controller that drives the shared 16-bit ALU to run multi-precision (N x 16-bit) add/subtract.
- Issues ADDC/SUBC one word per cycle, least-significant word first, chaining carry/borrow through an internal flag register.
- Reads operand words from, and writes result words back to, a word-indexed operand store.
- Requests the ALU through a req/gnt pair so that the ALU arbiter can interleave other traffic.

Parameters:
- MAX_WORDS, 8, maximum operand length in 16-bit words.
- IDX_W, 3, word index width; must equal clog2(MAX_WORDS).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin an operation; accepted only in IDLE.
- op_sub  in  1  0 = add (ADDC chain), 1 = subtract (SUBC chain); sampled at accepted start.
- num_words  in  IDX_W+1  operation length in words, 0..MAX_WORDS; sampled at accepted start.
- cin  in  1  initial carry/borrow for word 0; sampled at accepted start.
- rd_idx  out  IDX_W  word index presented to the operand store.
- a_word  in  16  operand A word at rd_idx, combinational, same cycle.
- b_word  in  16  operand B word at rd_idx, combinational, same cycle.
- alu_req  out  1  ALU request.
- alu_gnt  in  1  ALU grant for the current cycle.
- alu_operand1  out  16  driven with a_word.
- alu_operand2  out  16  driven with b_word.
- alu_carry_in  out  1  current chained carry flag.
- alu_opcode  out  4  `ADDC or `SUBC from the team opcode header.
- alu_result  in  16  ALU result, combinational.
- alu_carry_out  in  1  ALU carry/borrow out.
- alu_zero  in  1  ALU zero flag.
- wr_en  out  1  result write strobe.
- wr_idx  out  IDX_W  result word index.
- wr_data  out  16  result word.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- carry_final  out  1  final carry/borrow, held until the next accepted start.
- zero_all  out  1  1 when every result word was zero, held until the next accepted start.

Behaviour:
- Reset values:
  - state = IDLE.
  - idx = 0, rd_idx = 0, wr_idx = 0.
  - alu_req = 0, wr_en = 0, busy = 0, done = 0.
  - carry_final = 0, zero_all = 0, carry register = 0.
  - alu_opcode = `ADDC, alu_operand1/2 = 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start with num_words >= 1: latch op_sub, num_words and cin; carry register = cin; zero accumulator = 1; idx = 0; go to RUN.
  - On start with num_words = 0: carry_final = cin, zero_all = 1, no writes, go to DONE.
  - Any num_words > MAX_WORDS is clamped to MAX_WORDS.
- RUN, every cycle:
  - alu_req = 1, rd_idx = idx.
  - Operands and carry are driven combinationally: alu_operand1 = a_word, alu_operand2 = b_word, alu_carry_in = carry register.
  - alu_opcode = `SUBC if op_sub, else `ADDC.
- RUN, when alu_gnt = 1 (combinational outputs):
  - wr_en = 1, wr_idx = idx, wr_data = alu_result.
- RUN, when alu_gnt = 1 (at the clock edge):
  - carry register <= alu_carry_out.
  - zero accumulator <= accumulator & alu_zero.
  - idx <= idx + 1.
  - If idx == len-1: go to DONE, load carry_final and zero_all from the final values.
- RUN, when alu_gnt = 0:
  - wr_en = 0; state, idx and carry register hold; alu_req stays 1.
- DONE:
  - done = 1 for exactly one cycle, alu_req = 0, then go to IDLE.
- Latency: with continuous grant, done is asserted in cycle N+1 after the start cycle. Each cycle without grant adds one cycle.
- Start while busy is ignored, with no effect on the operation in flight.
- Subtract semantics are per-word operand1 - (operand2 + borrow); borrow out = 1 signals an underflow.
- wr_en is never asserted outside RUN, and never without alu_gnt.
- Reset mid-operation:
  - Returns to IDLE immediately, with no done pulse and no further writes.
  - Partially written words are left as written.
- idx never wraps: the maximum value reached is MAX_WORDS-1.

Test Plan:
- Add: N=2, A = 0x0001_FFFF, B = 0x0000_0001, cin=0, grant held.
  - Writes word0 = 0x0000 then word1 = 0x0002 in consecutive cycles.
  - done in cycle 3; carry_final = 0, zero_all = 0.
- Subtract: N=2, A = 0x0000_0000, B = 0x0000_0001.
  - Writes 0xFFFF, 0xFFFF.
  - carry_final = 1, zero_all = 0; alu_opcode = `SUBC throughout RUN.
- Grant stall: N=3 add with alu_gnt low for 2 cycles at word 1.
  - Word 1 is written once, after grant returns.
  - done in cycle 6; alu_carry_in holds during the stall.
- Zero, empty and overflow cases:
  - N=4 add with A = B = 0: four zero writes, zero_all = 1.
  - N=0 with cin=1: no writes, done in cycle 1, carry_final = 1.
  - A = B = 0xFFFF x8 (N=8): last write 0xFFFF, carry_final = 1.
- Start while busy: start pulse during RUN of an N=2 op.
  - Ignored: exactly 2 writes and one done pulse.
- Reset at RUN word 1 of N=4:
  - Next cycle busy = 0, wr_en = 0, done never pulses.
  - A new start then runs normally from word 0.
